// File: rtl/wb_uart.sv
// Wishbone classic UART: 8N1 transmitter fed by a TX FIFO, single-byte receive buffer,
// four word registers (DATA, STATUS, DIVISOR, CTRL) and a level interrupt.
module wb_uart #(
    parameter logic [15:0] DEFAULT_DIV = 16'd433,
    parameter int unsigned TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq,
    output logic        tx,
    input  logic        rx
);

    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0] PTR_WRAP = {1'b1, {PW{1'b0}}};

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_DIV    = 2'd2,
        REG_CTRL   = 2'd3
    } reg_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // Bus decode
    logic        bus_req;
    logic        bus_wr;
    logic        bus_rd;
    reg_t        reg_sel;
    logic [31:0] rd_mux;

    // Configuration
    logic [15:0] divisor;
    logic        rx_irq_en;
    logic        tx_irq_en;

    // TX FIFO
    logic [7:0]  fifo_mem [TX_DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        tx_full;
    logic        fifo_empty;
    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  fifo_head;

    // TX FSM
    uart_state_t tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line_n;
    logic        tx_empty;

    // RX path
    logic        rx_s1;
    logic        rx_sync;
    logic        rx_prev;
    logic        rx_fall;
    uart_state_t rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_stop_sample;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overrun;
    logic        rx_frame_err;
    logic        rx_read;
    logic        err_clr;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

    assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign bus_wr  = bus_req & wb_we_i;
    assign bus_rd  = bus_req & ~wb_we_i;
    assign reg_sel = reg_t'(wb_adr_i[3:2]);

    assign tx_push = bus_wr && (reg_sel == REG_DATA) && wb_sel_i[0] && !tx_full;
    assign rx_read = bus_rd && (reg_sel == REG_DATA);
    assign err_clr = bus_wr && (reg_sel == REG_CTRL) && wb_sel_i[1] && wb_dat_i[8];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign tx_full    = ((wr_ptr ^ rd_ptr) == PTR_WRAP);
    assign fifo_head  = fifo_mem[rd_ptr[PW-1:0]];
    assign tx_empty   = fifo_empty && (tx_state == S_IDLE);

    assign irq = (rx_irq_en & rx_valid) | (tx_irq_en & tx_empty);

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_DATA:   rd_mux[7:0]  = rx_data;
            REG_STATUS: rd_mux[4:0]  = {rx_frame_err, rx_overrun, rx_valid, tx_empty, tx_full};
            REG_DIV:    rd_mux[15:0] = divisor;
            REG_CTRL:   rd_mux[1:0]  = {tx_irq_en, rx_irq_en};
            default:    rd_mux       = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            divisor   <= DEFAULT_DIV;
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
        end else begin
            wb_ack_o <= bus_req;
            wb_dat_o <= bus_rd ? rd_mux : '0;
            if (bus_wr && reg_sel == REG_DIV) begin
                if (wb_sel_i[0]) divisor[7:0]  <= wb_dat_i[7:0];
                if (wb_sel_i[1]) divisor[15:8] <= wb_dat_i[15:8];
            end
            if (bus_wr && reg_sel == REG_CTRL && wb_sel_i[0]) begin
                rx_irq_en <= wb_dat_i[0];
                tx_irq_en <= wb_dat_i[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr[PW-1:0]] <= wb_dat_i[7:0];
    end

    // Full is taken from the pre-pop pointers, so a push racing a pop on a full FIFO is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_line_n  = tx;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = fifo_head;
                    tx_cnt_n   = divisor;
                    tx_line_n  = 1'b0;
                    tx_state_n = S_START;
                end
            end
            S_START: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n   = divisor;
                    tx_bit_n   = '0;
                    tx_line_n  = tx_shift[0];
                    tx_state_n = S_DATA;
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = divisor;
                    if (tx_bit == 3'd7) begin
                        tx_line_n  = 1'b1;
                        tx_state_n = S_STOP;
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = tx_shift >> 1;
                        tx_line_n  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt == '0) begin
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = fifo_head;
                        tx_cnt_n   = divisor;
                        tx_line_n  = 1'b0;
                        tx_state_n = S_START;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_line_n;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    always_comb begin
        rx_state_n     = rx_state;
        rx_cnt_n       = rx_cnt;
        rx_bit_n       = rx_bit;
        rx_shift_n     = rx_shift;
        rx_stop_sample = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_n   = divisor >> 1;
                    rx_state_n = S_START;
                end
            end
            S_START: begin
                if (rx_cnt == '0) begin
                    if (!rx_sync) begin
                        rx_cnt_n   = divisor;
                        rx_bit_n   = '0;
                        rx_state_n = S_DATA;
                    end else begin
                        rx_state_n = S_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_n   = divisor;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt == '0) begin
                    rx_stop_sample = 1'b1;
                    rx_state_n     = S_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= rx;
            rx_sync  <= rx_s1;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // A DATA read on the store edge frees the buffer first, so the new byte lands without overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (err_clr) begin
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
            end
            if (rx_read) rx_valid <= 1'b0;
            if (rx_stop_sample) begin
                if (!rx_sync) begin
                    rx_frame_err <= 1'b1;
                end else if (rx_valid && !rx_read) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart: directed register/IRQ steps plus randomized TX bursts
// and RX bytes, checked against a frame-level model of the serial line.
module tb_wb_uart;

    localparam int HIST = 131072;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq;
    logic        tx;
    logic        rx;

    wb_uart #(.DEFAULT_DIV(16'd433), .TX_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .irq      (irq),
        .tx       (tx),
        .rx       (rx)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc_cnt = 0;
    int   last_ack = 0;
    logic tx_hist [HIST];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // tx_hist[n] holds the line level during the cycle following rising edge n
    always @(negedge clk) tx_hist[cyc_cnt % HIST] = tx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb(input logic w, input logic [1:0] r, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] q);
        logic got;
        got = 1'b0;
        q = '0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = w;
        wb_adr_i = {r, 2'($urandom_range(0, 3))};
        wb_sel_i = s;
        wb_dat_i = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o) begin
                got = 1'b1;
                q = wb_dat_o;
                last_ack = cyc_cnt;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        chk("wb_ack_seen", 32'(got), 32'd1);
    endtask

    task automatic wr(input logic [1:0] r, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] dummy;
        wb(1'b1, r, s, d, dummy);
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] q);
        wb(1'b0, r, 4'hF, $urandom, q);
    endtask

    task automatic drain_tx();
        logic [31:0] q;
        logic done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            rd(2'd1, q);
            if (q[1]) done = 1'b1;
        end
        chk("tx_drain", 32'(done), 32'd1);
    endtask

    // Expected line: each byte is start(0), 8 data bits LSB first, stop(1), every bit d+1 clocks, frames contiguous
    task automatic check_tx_stream(input int start, input logic [7:0] bytes[$], input int d);
        int errs;
        int idx;
        logic exp_bit;
        logic [7:0] b;
        chk("tx_idle_at_ack", 32'(tx_hist[(start - 1) % HIST]), 32'd1);
        foreach (bytes[i]) begin
            errs = 0;
            b = bytes[i];
            for (int k = 0; k < 10; k++) begin
                exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                for (int c = 0; c <= d; c++) begin
                    idx = start + (i * 10 + k) * (d + 1) + c;
                    if (tx_hist[idx % HIST] !== exp_bit) errs++;
                end
            end
            chk($sformatf("tx_frame%0d_%02h_bad_clocks", i, b), 32'(errs), 32'd0);
        end
        chk("tx_idle_after", 32'(tx_hist[(start + bytes.size() * 10 * (d + 1)) % HIST]), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d, output int fall);
        fall = cyc_cnt;
        for (int k = 0; k < 10; k++) begin
            rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            step(d + 1);
        end
        rx = 1'b1;
    endtask

    // rx_valid (seen through irq with only rx_irq_en set) must rise 3 + d/2 + 9(d+1) clocks after the pin edge, +/-1
    task automatic check_rx_latency(input int fall, input int d);
        int lat;
        int exp_lat;
        logic seen;
        seen = 1'b0;
        lat = -1;
        exp_lat = 3 + (d >> 1) + 9 * (d + 1);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (irq) begin
                seen = 1'b1;
                lat = cyc_cnt - (fall + 1);
            end else begin
                step(1);
            end
        end
        chk($sformatf("rx_latency_%0d_vs_%0d", lat, exp_lat),
            32'(seen && lat >= exp_lat - 1 && lat <= exp_lat + 1), 32'd1);
    endtask

    logic [31:0] q;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    int          d;
    int          n;
    int          start;
    int          fall;

    initial begin
        rst = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_sel_i = '0;
        wb_dat_i = '0;
        rx = 1'b1;
        step(3);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        rst = 1'b0;
        step(1);

        rd(2'd1, q); chk("rst_status", q, 32'h2);
        rd(2'd2, q); chk("rst_divisor", q, 32'h1B1);
        rd(2'd3, q); chk("rst_ctrl", q, 32'h0);
        rd(2'd0, q); chk("rst_rx_data", q, 32'h0);

        wr(2'd2, 4'b0010, 32'hFFFF_12FF);
        rd(2'd2, q); chk("div_byte1_only", q, 32'h12B1);
        wr(2'd2, 4'b0011, 32'hABCD_0003);
        d = 3;
        rd(2'd2, q); chk("div_set3", q, 32'h3);
        wr(2'd1, 4'hF, 32'hFFFF_FFFF);
        rd(2'd1, q); chk("status_write_ignored", q, 32'h2);
        wr(2'd0, 4'b0010, 32'h77);
        rd(2'd1, q); chk("data_write_no_sel0", q, 32'h2);

        wr(2'd0, 4'b0001, 32'hA5);
        start = last_ack + 1;
        drain_tx();
        exp_q = '{8'hA5};
        check_tx_stream(start, exp_q, d);
        rd(2'd1, q); chk("tx_empty_after_frame", q, 32'h2);

        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            wr(2'd0, 4'b0001, 32'(i));
            if (i == 0) start = last_ack + 1;
            exp_q.push_back(8'(i));
        end
        rd(2'd1, q); chk("fifo_full_status", q, 32'h1);
        wr(2'd0, 4'b0001, 32'hFF);
        drain_tx();
        check_tx_stream(start, exp_q, d);

        for (int r = 0; r < 3; r++) begin
            d = $urandom_range(1, 6);
            wr(2'd2, 4'b0011, {16'($urandom), 16'(d)});
            rd(2'd2, q); chk("div_random", q, 32'(d));
            n = $urandom_range(1, 8);
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                wr(2'd0, 4'b0001, {24'($urandom), b});
                if (i == 0) start = last_ack + 1;
                exp_q.push_back(b);
            end
            drain_tx();
            check_tx_stream(start, exp_q, d);
        end

        d = 3;
        wr(2'd2, 4'b0011, 32'h3);
        send_rx(8'h3C, 1'b1, d, fall);
        send_rx(8'h7E, 1'b1, d, fall);
        step(4);
        rd(2'd0, q); chk("rx_first_byte_kept", q, 32'h3C);
        rd(2'd1, q); chk("rx_overrun_status", q, 32'h0A);
        rd(2'd0, q); chk("rx_stale_read", q, 32'h3C);
        rd(2'd1, q); chk("rx_stale_no_effect", q, 32'h0A);
        wr(2'd3, 4'b0011, 32'h100);
        rd(2'd1, q); chk("rx_overrun_cleared", q, 32'h2);

        send_rx(8'hA5, 1'b0, d, fall);
        step(4);
        rd(2'd1, q); chk("rx_frame_err_status", q, 32'h12);
        wr(2'd3, 4'b0011, 32'h100);
        rd(2'd1, q); chk("rx_frame_err_cleared", q, 32'h2);

        rx = 1'b0;
        step(1);
        rx = 1'b1;
        step(20);
        rd(2'd1, q); chk("rx_glitch_ignored", q, 32'h2);

        wr(2'd3, 4'b0001, 32'h3);
        chk("irq_tx_empty", 32'(irq), 32'd1);
        wr(2'd3, 4'b0001, 32'h1);
        chk("irq_rx_only_idle", 32'(irq), 32'd0);
        send_rx(8'h55, 1'b1, d, fall);
        check_rx_latency(fall, d);
        chk("irq_rx_valid", 32'(irq), 32'd1);
        rd(2'd0, q); chk("rx_byte_55", q, 32'h55);
        chk("irq_falls_on_read_ack", 32'(irq), 32'd0);

        for (int r = 0; r < 4; r++) begin
            d = $urandom_range(2, 7);
            wr(2'd2, 4'b0011, 32'(d));
            b = 8'($urandom);
            send_rx(b, 1'b1, d, fall);
            check_rx_latency(fall, d);
            rd(2'd0, q); chk($sformatf("rx_random_%0d", r), q, {24'h0, b});
            rd(2'd1, q); chk("rx_random_status", q, 32'h2);
        end

        wr(2'd3, 4'b0001, 32'h0);
        wr(2'd2, 4'b0011, 32'h3);
        wr(2'd0, 4'b0001, 32'h00);
        wr(2'd0, 4'b0001, 32'h5A);
        step(6);
        chk("midframe_tx_low", 32'(tx), 32'd0);
        rst = 1'b1;
        step(1);
        chk("midframe_rst_tx_high", 32'(tx), 32'd1);
        step(1);
        rst = 1'b0;
        step(1);
        rd(2'd1, q); chk("post_rst_status", q, 32'h2);
        rd(2'd2, q); chk("post_rst_divisor", q, 32'h1B1);
        step(20);
        chk("post_rst_tx_idle", 32'(tx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
